// File: rtl/fdiv_meter_pkg.sv
// Shared types and default widths for the divider-output frequency meter.
package fdiv_meter_pkg;

    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_GATE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } meter_state_e;

endpackage

// File: rtl/fdiv_edge_sync.sv
// Two-flop synchroniser for the asynchronous divider output, plus a third
// flop that turns each synchronised rising edge into a one-cycle pulse.
module fdiv_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Reset to 0 so a level already high at release yields at most one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise_pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/fdiv_freq_meter.sv
// Counts rising edges of a divider output over a gate window of gate_len
// clk cycles and reports a saturating count with a sticky overflow flag.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; last result held on count/overflow
//   ST_COUNT | gate window open, one cycle per gate_cnt decrement
//   ST_DONE  | result valid, done pulses for this single cycle
module fdiv_freq_meter
    import fdiv_meter_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int GATE_WIDTH = DEF_GATE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fdiv_in,
    input  logic                  start,
    input  logic [GATE_WIDTH-1:0] gate_len,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow
);

    logic                  edge_pulse;
    meter_state_e          state_q;
    logic [GATE_WIDTH-1:0] gate_cnt_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  busy_q;
    logic                  done_q;

    fdiv_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (fdiv_in),
        .rise_pulse (edge_pulse)
    );

    // Saturating edge accumulation; an edge that cannot be counted sets overflow.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (edge_pulse) begin
            if (&count_q) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        gate_cnt_q <= gate_len;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (gate_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    gate_cnt_q <= gate_cnt_q - GATE_WIDTH'(1);
                    count_q    <= count_d;
                    overflow_q <= overflow_d;
                    // Last window cycle still accepts an edge before closing.
                    if (gate_cnt_q <= GATE_WIDTH'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fdiv_freq_meter.sv
// Directed bench for fdiv_freq_meter: a 16-bit instance for timing and
// counting scenarios and a 4-bit-count instance for saturation.
module tb_fdiv_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] gate_len;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        overflow;

    logic        gen_a;
    logic        man_a;
    int          half_a = 0;
    wire logic   fdiv_a = (half_a != 0) ? gen_a : man_a;

    logic        fdiv_b;
    logic        start_b;
    logic [15:0] gate_len_b;
    logic        busy_b;
    logic        done_b;
    logic [3:0]  count_b;
    logic        overflow_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fdiv_freq_meter #(.CNT_WIDTH(16), .GATE_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fdiv_in  (fdiv_a),
        .start    (start),
        .gate_len (gate_len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    fdiv_freq_meter #(.CNT_WIDTH(4), .GATE_WIDTH(16)) dut_w4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .fdiv_in  (fdiv_b),
        .start    (start_b),
        .gate_len (gate_len_b),
        .busy     (busy_b),
        .done     (done_b),
        .count    (count_b),
        .overflow (overflow_b)
    );

    // Free-running divider model for the main instance; toggles stay off clk edges.
    initial begin
        gen_a = 1'b0;
        forever begin
            if (half_a == 0) begin
                #1;
            end else begin
                #2;
                while (half_a != 0) begin
                    gen_a = ~gen_a;
                    #(half_a);
                end
            end
        end
    end

    // 40-unit period divider for the narrow-count instance.
    initial begin
        fdiv_b = 1'b0;
        #2;
        forever #20 fdiv_b = ~fdiv_b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Pulses start for one cycle and waits for done; optional manual fdiv
    // pulses (3 high / 3 low cycles) start at window cycle 'first'.
    task automatic measure(input logic [15:0] gl, input int first, input int npulse,
                           output int cycles);
        gate_len = gl;
        start    = 1'b1;
        cycles   = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (npulse > 0 && cycles >= first) begin
                if ((cycles - first) % 6 == 0 && (cycles - first) / 6 < npulse) man_a = 1'b1;
                if ((cycles - first) % 6 == 3) man_a = 1'b0;
            end
        end while (!done && cycles < 3000);
        man_a = 1'b0;
    endtask

    task automatic measure_b(input logic [15:0] gl, output int cycles);
        gate_len_b = gl;
        start_b    = 1'b1;
        cycles     = 0;
        do begin
            @(negedge clk);
            start_b = 1'b0;
            cycles++;
        end while (!done_b && cycles < 3000);
    endtask

    initial begin
        int cyc;
        int nd;
        int dcyc;
        int prev;
        logic any;

        rst_n      = 1'b0;
        start      = 1'b0;
        gate_len   = '0;
        man_a      = 1'b0;
        start_b    = 1'b0;
        gate_len_b = '0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_count", 32'(count), 0);
        check_val("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // zero-length window
        measure(16'd0, 0, 0, cyc);
        check_val("gl0_latency", 32'(cyc), 1);
        check_val("gl0_busy", 32'(busy), 1);
        check_val("gl0_count", 32'(count), 0);
        check_val("gl0_ovf", 32'(overflow), 0);
        @(negedge clk);
        check_val("gl0_done_width", 32'(done), 0);
        check_val("gl0_busy_width", 32'(busy), 0);

        // edge landing in the last window cycle is counted
        measure(16'd10, 8, 1, cyc);
        check_val("last_cyc_latency", 32'(cyc), 11);
        check_val("last_cyc_count", 32'(count), 1);
        @(negedge clk);
        check_val("last_cyc_done_width", 32'(done), 0);
        repeat (4) @(negedge clk);

        // edge one cycle later falls in DONE and is not counted
        measure(16'd10, 9, 1, cyc);
        check_val("past_win_count", 32'(count), 0);
        repeat (5) @(negedge clk);

        // three exact manual pulses
        measure(16'd40, 5, 3, cyc);
        check_val("three_latency", 32'(cyc), 41);
        check_val("three_count", 32'(count), 3);
        check_val("three_ovf", 32'(overflow), 0);
        repeat (5) @(negedge clk);

        // 100-unit divider period, 1000-cycle window
        half_a = 50;
        repeat (2) @(negedge clk);
        measure(16'd1000, 0, 0, cyc);
        check_val("w1000_latency", 32'(cyc), 1001);
        check_val("w1000_count", 32'(count), 32'(clamp(int'(count), 99, 101)));
        check_val("w1000_ovf", 32'(overflow), 0);
        @(negedge clk);
        check_val("w1000_done_width", 32'(done), 0);

        // start re-pulsed and gate_len changed while busy
        gate_len = 16'd200;
        start    = 1'b1;
        cyc      = 0;
        nd       = 0;
        dcyc     = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == 5 || cyc == 50);
            if (cyc == 5) gate_len = 16'd7;
            if (done) begin
                nd++;
                if (dcyc == 0) dcyc = cyc;
            end
        end while (cyc < 215);
        check_val("ign_start_done_at", 32'(dcyc), 201);
        check_val("ign_start_ndone", 32'(nd), 1);
        check_val("ign_start_count", 32'(count), 32'(clamp(int'(count), 19, 21)));
        check_val("ign_start_busy", 32'(busy), 0);

        // start held high: back-to-back windows
        half_a   = 25;
        repeat (3) @(negedge clk);
        gate_len = 16'd10;
        start    = 1'b1;
        cyc      = 0;
        nd       = 0;
        prev     = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (done) begin
                nd++;
                check_val("b2b_interval", 32'(cyc - prev), (nd == 1) ? 32'd11 : 32'd12);
                check_val("b2b_count", 32'(count), 32'(clamp(int'(count), 1, 3)));
                prev = cyc;
            end
        end while (nd < 5 && cyc < 200);
        start = 1'b0;
        check_val("b2b_ndone", 32'(nd), 5);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("b2b_idle", 32'(busy), 0);

        // reset in the middle of a window
        half_a   = 50;
        repeat (2) @(negedge clk);
        gate_len = 16'd1000;
        start    = 1'b1;
        cyc      = 0;
        nd       = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) nd++;
        end while (cyc < 300);
        check_val("abort_pre_ndone", 32'(nd), 0);
        check_val("abort_pre_busy", 32'(busy), 1);
        check_val("abort_pre_cnt_nz", 32'(count != 0), 1);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_count", 32'(count), 0);
        check_val("abort_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        any = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) any = 1'b1;
        end
        check_val("abort_no_done", 32'(any), 0);
        measure(16'd1000, 0, 0, cyc);
        check_val("post_rst_latency", 32'(cyc), 1001);
        check_val("post_rst_count", 32'(count), 32'(clamp(int'(count), 99, 101)));
        check_val("post_rst_ovf", 32'(overflow), 0);

        // 4-bit count saturation and sticky overflow
        measure_b(16'd100, cyc);
        check_val("sat_latency", 32'(cyc), 101);
        check_val("sat_count", 32'(count_b), 15);
        check_val("sat_ovf", 32'(overflow_b), 1);
        repeat (3) @(negedge clk);
        check_val("sat_hold_count", 32'(count_b), 15);
        check_val("sat_hold_ovf", 32'(overflow_b), 1);
        measure_b(16'd20, cyc);
        check_val("unsat_count", 32'(count_b), 32'(clamp(int'(count_b), 4, 6)));
        check_val("unsat_ovf_cleared", 32'(overflow_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fdiv_freq_meter.md
FDIV_FREQ_METER -- requirements
Module: fdiv_freq_meter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the edge count result.
REQ-002 SHALL have parameter GATE_WIDTH, default 16, width of the gate length in clk cycles.
REQ-003 SHALL have port clk  input  1  single measurement clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port fdiv_in  input  1  divider output Fout, asynchronous to clk.
REQ-006 SHALL have port start  input  1  measurement request, sampled only in IDLE.
REQ-007 SHALL have port gate_len  input  GATE_WIDTH  window length in clk cycles, latched on start acceptance.
REQ-008 SHALL have port busy  output  1  high in COUNT and DONE.
REQ-009 SHALL have port done  output  1  single-cycle pulse when result is valid.
REQ-010 SHALL have port count  output  CNT_WIDTH  fdiv_in rising edges counted in last window.
REQ-011 SHALL have port overflow  output  1  count saturated during last window.

Function
REQ-012 SHALL synchronise fdiv_in through two flops, then a third flop for edge detect; edge_pulse = sync2 & ~sync3, one clk cycle wide.
REQ-013 SHALL impose 3 clk cycles from fdiv_in rise to edge_pulse; fdiv_in high/low phases SHALL each exceed 1 clk period for exact counting.
REQ-014 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-015 IDLE and start=1: latch gate_len into gate_cnt, clear count and overflow, go to COUNT (or DONE if gate_len==0).
REQ-016 COUNT: each cycle decrement gate_cnt; increment count when edge_pulse=1; go to DONE in the cycle gate_cnt==1.
REQ-017 The window SHALL be exactly gate_len cycles, starting the cycle after acceptance, and include edge_pulse in its last cycle.
REQ-018 count SHALL saturate at all-ones; an edge_pulse arriving at saturation SHALL set overflow, which is sticky until next acceptance.
REQ-019 DONE: assert done for one cycle, then return to IDLE; count/overflow SHALL hold until the next acceptance.
REQ-020 start while busy=1 SHALL be ignored (not queued); start held high in IDLE SHALL launch back-to-back measurements, one per IDLE visit.
REQ-021 gate_len==0 SHALL yield done one cycle after acceptance with count=0, overflow=0.
REQ-022 Changes to gate_len during COUNT SHALL not affect the running window.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, count=0, overflow=0, gate_cnt=0, all three sync flops=0.
REQ-024 Reset mid-COUNT SHALL abort the measurement with no done pulse; first start after release SHALL behave as from power-up.
REQ-025 An fdiv_in high at reset release SHALL not generate a spurious edge_pulse (sync flops reset to 0 gives at most one, counted only if within a window).

Structure
REQ-026 Package fdiv_meter_pkg SHALL hold the FSM state type (IDLE, COUNT, DONE) and default CNT_WIDTH/GATE_WIDTH constants.
REQ-027 Synchroniser plus edge detect SHALL be sub-module fdiv_edge_sync (ports clk, rst_n, async_in, rise_pulse).
REQ-028 count SHALL be driven directly from registers, no combinational path from fdiv_in.

Verification
REQ-029 clk 100 MHz, fdiv_in period 100 ns 50% duty, gate_len=1000, start pulse -> done 1001 cycles after acceptance, count in {99,100,101}, overflow=0.
REQ-030 gate_len=0, start -> done next cycle, count=0, busy high for exactly 1 cycle.
REQ-031 CNT_WIDTH=4, fdiv_in period 40 ns, gate_len=100 -> count=15, overflow=1.
REQ-032 start pulsed again at cycles 5 and 50 of a 200-cycle window -> ignored, single done after 200 window cycles.
REQ-033 rst_n low at cycle 300 of a 1000-cycle window -> busy=0, count=0 immediately, no done; new start afterwards -> correct result.
REQ-034 start held high, gate_len=10, fdiv_in period 50 ns -> done every 12 cycles, count in {1,2,3} each time.
